// File: rtl/uart_rx_deframe.sv
// UART receive deframe: checks start/stop/parity of each captured frame and buffers
// payload plus per-byte error flags in a first-word-fall-through FIFO drained by rd_en.
module uart_rx_deframe #(
   parameter int DEPTH      = 4,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic                     baud_clk,
   input  logic                     rst,
   input  logic [10:0]              frame_in,
   input  logic                     def_en,
   input  logic                     rd_en,
   input  logic                     err_clr,
   output logic [7:0]               rx_data,
   output logic                     rx_valid,
   output logic                     parity_err,
   output logic                     frame_err,
   output logic                     overrun,
   output logic [7:0]               err_cnt,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [9:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          chk_frame;
   logic          chk_parity;
   logic          any_err;
   logic          full;
   logic          do_wr;
   logic          do_rd;
   logic          drop;

   assign chk_frame  = frame_in[0] | ~frame_in[10];
   assign chk_parity = (^frame_in[9:1]) != PARITY_ODD;
   assign any_err    = chk_frame | chk_parity;

   assign full     = (fifo_count == FULL_CNT);
   assign rx_valid = (fifo_count != '0);
   assign do_rd    = rd_en & rx_valid;
   // A full FIFO still accepts a frame when the head is popped in the same cycle.
   assign do_wr    = def_en & (~full | rd_en);
   assign drop     = def_en & full & ~rd_en;

   assign {parity_err, frame_err, rx_data} = rx_valid ? mem[rd_ptr] : 10'd0;

   always_ff @(posedge baud_clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= {chk_parity, chk_frame, frame_in[8:1]};
      end
   end

   always_ff @(posedge baud_clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overrun    <= 1'b0;
         err_cnt    <= 8'd0;
      end else begin
         if (do_wr) begin
            wr_ptr <= AW'(wr_ptr + 1'b1);
         end
         if (do_rd) begin
            rd_ptr <= AW'(rd_ptr + 1'b1);
         end
         case ({do_wr, do_rd})
            2'b10:   fifo_count <= (AW+1)'(fifo_count + 1'b1);
            2'b01:   fifo_count <= (AW+1)'(fifo_count - 1'b1);
            default: fifo_count <= fifo_count;
         endcase

         // A drop in the clearing cycle wins, so no lost frame goes unreported.
         if (drop) begin
            overrun <= 1'b1;
         end else if (err_clr) begin
            overrun <= 1'b0;
         end

         if (err_clr) begin
            err_cnt <= (do_wr && any_err) ? 8'd1 : 8'd0;
         end else if (do_wr && any_err && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_deframe.sv
// Directed bench for uart_rx_deframe: even-parity instance for the main checks,
// odd-parity instance sharing the same inputs for the parity-polarity checks.
module tb_uart_rx_deframe;

   localparam int DEPTH = 4;

   logic        baud_clk = 1'b0;
   logic        rst;
   logic [10:0] frame_in;
   logic        def_en;
   logic        rd_en;
   logic        err_clr;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        parity_err;
   logic        frame_err;
   logic        overrun;
   logic [7:0]  err_cnt;
   logic [2:0]  fifo_count;

   logic [7:0]  o_rx_data;
   logic        o_rx_valid;
   logic        o_parity_err;
   logic        o_frame_err;
   logic        o_overrun;
   logic [7:0]  o_err_cnt;
   logic [2:0]  o_fifo_count;

   int total = 0;
   int bad   = 0;

   always #5 baud_clk = ~baud_clk;

   uart_rx_deframe #(.DEPTH(DEPTH), .PARITY_ODD(1'b0)) dut (
      .baud_clk(baud_clk), .rst(rst), .frame_in(frame_in), .def_en(def_en),
      .rd_en(rd_en), .err_clr(err_clr), .rx_data(rx_data), .rx_valid(rx_valid),
      .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun),
      .err_cnt(err_cnt), .fifo_count(fifo_count)
   );

   uart_rx_deframe #(.DEPTH(DEPTH), .PARITY_ODD(1'b1)) dut_odd (
      .baud_clk(baud_clk), .rst(rst), .frame_in(frame_in), .def_en(def_en),
      .rd_en(rd_en), .err_clr(err_clr), .rx_data(o_rx_data), .rx_valid(o_rx_valid),
      .parity_err(o_parity_err), .frame_err(o_frame_err), .overrun(o_overrun),
      .err_cnt(o_err_cnt), .fifo_count(o_fifo_count)
   );

   typedef struct {
      logic [10:0] frame;
      logic [7:0]  data;
      logic        pe;
      logic        fe;
      logic        pe_odd;
      logic [7:0]  ecnt;
   } vec_t;

   vec_t tbl[8];

   function automatic logic [10:0] mk(input logic s, input logic [7:0] d,
                                      input logic p, input logic st);
      return {st, p, d, s};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge baud_clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d, input logic err, input logic clr);
      frame_in = mk(err, d, ^d, 1'b1);
      def_en   = 1'b1;
      err_clr  = clr;
      tick();
      def_en   = 1'b0;
      err_clr  = 1'b0;
   endtask

   task automatic pop();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic drain(input string name, input logic [7:0] first, input int n);
      for (int k = 0; k < n; k++) begin
         chk(name, rx_data, first + 8'(k));
         pop();
      end
      chk({name, "_empty"}, rx_valid, 1'b0);
   endtask

   logic [7:0] q[$];
   logic [7:0] d;
   logic [7:0] exp_d;

   initial begin
      tbl[0] = '{mk(1'b0, 8'hA5, 1'b1, 1'b1), 8'hA5, 1'b1, 1'b0, 1'b0, 8'd1};
      tbl[1] = '{mk(1'b0, 8'h3C, 1'b0, 1'b0), 8'h3C, 1'b0, 1'b1, 1'b1, 8'd2};
      tbl[2] = '{mk(1'b1, 8'h0F, 1'b0, 1'b1), 8'h0F, 1'b0, 1'b1, 1'b1, 8'd3};
      tbl[3] = '{mk(1'b0, 8'h80, 1'b1, 1'b1), 8'h80, 1'b0, 1'b0, 1'b1, 8'd3};
      tbl[4] = '{mk(1'b0, 8'hFF, 1'b0, 1'b1), 8'hFF, 1'b0, 1'b0, 1'b1, 8'd3};
      tbl[5] = '{mk(1'b1, 8'h07, 1'b0, 1'b0), 8'h07, 1'b1, 1'b1, 1'b0, 8'd4};
      tbl[6] = '{mk(1'b0, 8'h01, 1'b0, 1'b1), 8'h01, 1'b1, 1'b0, 1'b0, 8'd5};
      tbl[7] = '{mk(1'b0, 8'h01, 1'b1, 1'b1), 8'h01, 1'b0, 1'b0, 1'b1, 8'd5};

      rst = 1'b1; def_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
      frame_in = 11'b1_0_01010101_0;

      // Frames offered during reset must not land in the FIFO.
      def_en = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("rst_valid", rx_valid, 1'b0);
         chk("rst_count", fifo_count, 3'd0);
         chk("rst_data", {parity_err, frame_err, rx_data}, 10'd0);
         chk("rst_flags", {overrun, err_cnt}, 9'd0);
      end
      def_en = 1'b0;
      rst    = 1'b0;
      tick();
      chk("post_rst_count", fifo_count, 3'd0);

      frame_in = 11'b1_0_01010101_0;
      def_en = 1'b1; tick(); def_en = 1'b0;
      chk("first_valid", rx_valid, 1'b1);
      chk("first_data", rx_data, 8'h55);
      chk("first_flags", {parity_err, frame_err}, 2'b00);
      chk("first_count", fifo_count, 3'd1);
      pop();
      chk("first_empty_data", {rx_valid, rx_data}, 9'd0);

      for (int i = 0; i < 8; i++) begin
         frame_in = tbl[i].frame;
         def_en = 1'b1; tick(); def_en = 1'b0;
         chk($sformatf("vec%0d_valid", i), rx_valid, 1'b1);
         chk($sformatf("vec%0d_data", i), rx_data, tbl[i].data);
         chk($sformatf("vec%0d_pe", i), parity_err, tbl[i].pe);
         chk($sformatf("vec%0d_fe", i), frame_err, tbl[i].fe);
         chk($sformatf("vec%0d_pe_odd", i), o_parity_err, tbl[i].pe_odd);
         chk($sformatf("vec%0d_errcnt", i), err_cnt, tbl[i].ecnt);
         pop();
         chk($sformatf("vec%0d_empty", i), rx_valid, 1'b0);
      end

      // Fill, then one more frame with no read is dropped.
      for (int i = 0; i < 4; i++) push(8'h10 + 8'(i), 1'b0, 1'b0);
      chk("full_count", fifo_count, 3'd4);
      chk("full_no_overrun", overrun, 1'b0);
      push(8'h14, 1'b0, 1'b0);
      chk("drop_count", fifo_count, 3'd4);
      chk("drop_overrun", overrun, 1'b1);
      chk("drop_errcnt", err_cnt, 8'd5);
      drain("drop_order", 8'h10, 4);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      chk("clr_overrun", overrun, 1'b0);
      chk("clr_errcnt", err_cnt, 8'd0);

      pop();
      chk("empty_rd_count", fifo_count, 3'd0);
      chk("empty_rd_valid", rx_valid, 1'b0);

      // Full FIFO: simultaneous push and pop keeps occupancy and ordering.
      for (int i = 0; i < 4; i++) push(8'h20 + 8'(i), 1'b0, 1'b0);
      frame_in = mk(1'b0, 8'h24, ^8'h24, 1'b1);
      def_en = 1'b1; rd_en = 1'b1; tick(); def_en = 1'b0; rd_en = 1'b0;
      chk("sim_full_count", fifo_count, 3'd4);
      chk("sim_full_overrun", overrun, 1'b0);
      drain("sim_full_order", 8'h21, 4);

      frame_in = mk(1'b0, 8'h30, ^8'h30, 1'b1);
      def_en = 1'b1; rd_en = 1'b1; tick(); def_en = 1'b0; rd_en = 1'b0;
      chk("sim_empty_count", fifo_count, 3'd1);
      chk("sim_empty_data", rx_data, 8'h30);
      pop();

      // err_clr coinciding with an errored write and with a drop.
      push(8'h40, 1'b1, 1'b0);
      chk("err_before_clr", err_cnt, 8'd1);
      push(8'h41, 1'b1, 1'b1);
      chk("clr_with_err_write", err_cnt, 8'd1);
      push(8'h42, 1'b0, 1'b0);
      push(8'h43, 1'b0, 1'b0);
      chk("clr_fill_count", fifo_count, 3'd4);
      push(8'h44, 1'b1, 1'b1);
      chk("clr_with_drop_overrun", overrun, 1'b1);
      chk("clr_with_drop_errcnt", err_cnt, 8'd0);
      drain("clr_order", 8'h40, 4);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      chk("clr2_overrun", overrun, 1'b0);

      // 300 errored frames with steady reads: saturation plus pointer wrap.
      for (int i = 0; i < 300; i++) begin
         d = 8'(i * 7 + 3);
         frame_in = mk(1'b1, d, ^d, 1'b1);
         def_en = 1'b1;
         rd_en  = (q.size() >= 2);
         if (rd_en) begin
            exp_d = q.pop_front();
            chk("sat_order", rx_data, exp_d);
         end
         q.push_back(d);
         tick();
      end
      def_en = 1'b0; rd_en = 1'b0;
      chk("sat_errcnt", err_cnt, 8'd255);
      chk("sat_overrun", overrun, 1'b0);
      chk("sat_count", fifo_count, 3'(q.size()));
      while (q.size() > 0) begin
         exp_d = q.pop_front();
         chk("sat_drain", rx_data, exp_d);
         pop();
      end
      chk("sat_empty", rx_valid, 1'b0);

      // Reset mid-operation discards buffered bytes.
      push(8'h60, 1'b0, 1'b0);
      push(8'h61, 1'b1, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_count", fifo_count, 3'd0);
      chk("midrst_valid", {rx_valid, rx_data}, 9'd0);
      chk("midrst_errcnt", err_cnt, 8'd0);
      tick();
      rst = 1'b0;
      tick();
      tick();
      chk("midrst_after_count", fifo_count, 3'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_deframe.md
# uart_rx_deframe

Receive-side deframe stage of the full-duplex UART IP core. It sits directly downstream of the serial-to-parallel receive shifter. On each deframe-enable pulse it takes the captured 11-bit frame, checks start, stop and parity, and strips the framing bits. It buffers the 8-bit payload plus per-byte error flags in a small first-word-fall-through FIFO that the host drains with a read strobe.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity

Ports:
- baud_clk  input  1  baud clock, shared with the receive shifter
- rst  input  1  asynchronous, active-high reset
- frame_in  input  11  captured frame: [0] start, [8:1] D0..D7, [9] parity, [10] stop
- def_en  input  1  one-cycle pulse; frame_in is valid in this cycle
- rd_en  input  1  pop the head entry
- err_clr  input  1  clear the overrun flag and err_cnt
- rx_data  output  8  head payload, D7..D0
- rx_valid  output  1  FIFO non-empty
- parity_err  output  1  parity error flag of the head entry
- frame_err  output  1  framing error flag of the head entry
- overrun  output  1  sticky flag: a frame was dropped because the FIFO was full
- err_cnt  output  8  saturating count of frames written with any error
- fifo_count  output  log2(DEPTH)+1  current occupancy

## Operation
- All state is reset by rst, asynchronously. Reset values: pointers = 0, fifo_count = 0, rx_valid = 0, rx_data = 0, parity_err = 0, frame_err = 0, overrun = 0, err_cnt = 0.
- Checks are combinational on frame_in in the def_en cycle:
  - frame_err = (frame_in[0] != 0) | (frame_in[10] != 1)
  - parity_err = (^frame_in[9:1]) != PARITY_ODD. Even mode: total ones over data+parity must be even.
- Write: on a def_en edge, the entry {parity_err, frame_err, frame_in[8:1]} is written at the write pointer. This happens if the FIFO is not full, or if it is full and rd_en is also asserted.
- Drop: def_en while full and rd_en = 0. The frame is discarded, overrun is set, and FIFO contents are unchanged.
- Error count: err_cnt increments on every written frame with parity_err | frame_err. It saturates at 255. Dropped frames are not counted.
- Read: rd_en with rx_valid = 1 advances the read pointer. rd_en while empty is ignored and has no effect on pointers or flags.
- Simultaneous read and write:
  - Both pointers advance and fifo_count is unchanged.
  - When the FIFO is empty, def_en and rd_en in the same cycle result in a write only. rd_en is ignored because rx_valid = 0.
- Pointers wrap modulo DEPTH.
- Output presentation is first-word-fall-through: rx_data, parity_err and frame_err always reflect the entry at the read pointer. They hold 0 when empty.
- err_clr:
  - Clears overrun and err_cnt on the next edge.
  - If a drop occurs in the same cycle, overrun ends set.
  - If an errored write occurs in the same cycle, err_cnt ends at 1.
- Reset mid-operation: any buffered bytes are lost, and no partial write occurs after rst deasserts.

## Timing
- Single clock domain: baud_clk, rising edge.
- Write latency: def_en sampled at edge N. Then rx_valid = 1 and the head data are visible after edge N (when previously empty), and fifo_count is updated after edge N.
- Read: rd_en sampled at edge M. The next entry, or rx_valid = 0, is visible after edge M.
- overrun and err_cnt update on the same edge as the causing def_en.
- def_en pulses are at least one cycle apart; back-to-back pulses in consecutive cycles must also be handled.

## Test plan
- Reset: hold rst high for 3 cycles, then drive def_en → all outputs stay 0 during reset. After release, the frame 11'b1_0_01010101_0 (stop=1, parity=0, data 0x55, start=0) gives rx_data = 0x55, parity_err = 0, frame_err = 0, rx_valid = 1 one edge later.
- Error detection, even parity: frame data 0xA5 with parity = 1 → parity_err = 1. A frame with stop = 0 → frame_err = 1. A frame with start = 1 → frame_err = 1. Afterwards err_cnt = 3.
- Odd parity: with PARITY_ODD = 1, data 0x01 with parity = 0 → parity_err = 0; the same frame with parity = 1 → parity_err = 1.
- Full and overrun:
  - Write 5 frames 0x10..0x14 with no reads → fifo_count = 4, overrun = 1.
  - Pop 4 times → reads 0x10..0x13, and 0x14 is absent.
  - Pulse err_clr → overrun = 0, err_cnt = 0.
- Simultaneous access:
  - With the FIFO full, def_en and rd_en in the same cycle → count stays 4, overrun stays 0, and the new byte arrives last.
  - With the FIFO empty, both in the same cycle → count = 1.
- Saturation and wrap: write 300 errored frames interleaved with reads → err_cnt = 255, pointers wrap, and data order is preserved throughout.
